branch_resolve_unit: RTL

- Parametrised successor to the combinational jump-condition decoder.
- Holds an architectural flag register (sign, carry, zero) and resolves all eight branch opcodes against it.
- Computes the registered next PC and keeps a return-address stack (RAS) for call/return.
- Sits between the ALU/flag source and the PC register in the single-cycle datapath; every output is registered, so resolution latency is 1 cycle.

---
 rtl/branch_resolve_unit.sv | 121 ++++++++++++
 1 files changed

// File: rtl/branch_resolve_unit.sv
// Branch resolution stage: flag register, eight-way condition decode, registered
// next-PC selection and a circular return-address stack for BL/RET.
module branch_resolve_unit #(
    parameter int PC_WIDTH  = 32,
    parameter int PC_STEP   = 4,
    parameter int RAS_DEPTH = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         valid_in,
    input  logic [5:0]                   opcode,
    input  logic [PC_WIDTH-1:0]          pc_in,
    input  logic [PC_WIDTH-1:0]          target_in,
    input  logic                         flag_we,
    input  logic                         sign_in,
    input  logic                         carry_in,
    input  logic                         zero_in,
    input  logic                         flush,
    output logic                         valid_out,
    output logic                         taken,
    output logic [PC_WIDTH-1:0]          next_pc,
    output logic [2:0]                   flags_out,
    output logic [$clog2(RAS_DEPTH):0]   ras_count,
    output logic                         ras_overflow,
    output logic                         ras_underflow
);
    localparam int PW = $clog2(RAS_DEPTH);
    localparam logic [PC_WIDTH-1:0] STEP     = PC_WIDTH'(PC_STEP);
    localparam logic [PW:0]         CNT_FULL = (PW+1)'(RAS_DEPTH);

    localparam logic [5:0] OP_BLT  = 6'b000111;
    localparam logic [5:0] OP_BZ   = 6'b001000;
    localparam logic [5:0] OP_BNZ  = 6'b001001;
    localparam logic [5:0] OP_B    = 6'b001010;
    localparam logic [5:0] OP_BL   = 6'b001011;
    localparam logic [5:0] OP_RET  = 6'b001100;
    localparam logic [5:0] OP_BCY  = 6'b001101;
    localparam logic [5:0] OP_BNCY = 6'b001110;

    typedef struct packed {
        logic s;
        logic c;
        logic z;
    } flags_t;

    flags_t              flags_q, eff;
    logic                accept, cond, is_push, is_pop, ras_full, ras_empty;
    logic [PC_WIDTH-1:0] link;
    logic [PW-1:0]       top, top_m1;
    logic [PC_WIDTH-1:0] ras_mem [RAS_DEPTH];

    // Same-cycle forwarding lets a flag-setting op and its branch share a cycle.
    assign eff       = flag_we ? flags_t'({sign_in, carry_in, zero_in}) : flags_q;
    assign accept    = valid_in & ~flush;
    assign link      = pc_in + STEP;
    assign top_m1    = top - 1'b1;
    assign ras_full  = (ras_count == CNT_FULL);
    assign ras_empty = (ras_count == '0);
    assign flags_out = flags_q;

    always_comb begin
        cond    = 1'b0;
        is_push = 1'b0;
        is_pop  = 1'b0;
        case (opcode)
            OP_BLT:  cond = eff.s & ~eff.z;
            OP_BZ:   cond = ~eff.s & eff.z;
            OP_BNZ:  cond = ~eff.z;
            OP_B:    cond = 1'b1;
            OP_BL:   begin cond = 1'b1; is_push = accept; end
            OP_RET:  begin cond = 1'b1; is_pop  = accept; end
            OP_BCY:  cond = eff.c;
            OP_BNCY: cond = ~eff.c;
            default: cond = 1'b0;
        endcase
    end

    // When full, top already points at the oldest entry, so a push overwrites it.
    always_ff @(posedge clk) begin
        if (!rst && is_push)
            ras_mem[top] <= link;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            flags_q       <= '0;
            valid_out     <= 1'b0;
            taken         <= 1'b0;
            next_pc       <= '0;
            top           <= '0;
            ras_count     <= '0;
            ras_overflow  <= 1'b0;
            ras_underflow <= 1'b0;
        end else begin
            if (flag_we)
                flags_q <= eff;
            valid_out     <= accept;
            taken         <= accept & cond;
            ras_overflow  <= 1'b0;
            ras_underflow <= 1'b0;
            if (accept)
                next_pc <= cond ? target_in : link;
            if (is_push) begin
                top <= top + 1'b1;
                if (ras_full)
                    ras_overflow <= 1'b1;
                else
                    ras_count <= ras_count + 1'b1;
            end
            if (is_pop) begin
                if (ras_empty) begin
                    ras_underflow <= 1'b1;
                end else begin
                    next_pc   <= ras_mem[top_m1];
                    top       <= top_m1;
                    ras_count <= ras_count - 1'b1;
                end
            end
        end
    end
endmodule
